// File: rtl/snes_controller_reader_pkg.sv
// Shared constants and types for the SNES controller reader.
// Button indices follow the order in which the pad shifts its bits out.
package snes_pkg;

    localparam int NUM_BITS = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } state_t;

endpackage

// File: rtl/snes_controller_reader_if.sv
// Pad connector pins: the reader drives latch and clock, and the pad drives data back.
interface snes_controller_reader_if;

    logic snes_data;
    logic snes_latch;
    logic snes_clk;

    modport master (
        input  snes_data,
        output snes_latch,
        output snes_clk
    );

    modport slave (
        output snes_data,
        input  snes_latch,
        input  snes_clk
    );

endinterface

// File: rtl/snes_controller_reader_sync_2ff.sv
// Generic two-flop synchroniser for bringing an asynchronous input into the clk domain.
module sync_2ff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/snes_controller_reader.sv
// Periodically latches and clocks out the 16-bit SNES pad word, then publishes it
// as registered active-low button outputs with a one-cycle valid strobe.
module snes_controller_reader
    import snes_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic                        clk,
    input  logic                        reset,
    snes_controller_reader_if.master    pad,
    output logic [NUM_BITS-1:0]         buttons_n,
    output logic                        Up,
    output logic                        Down,
    output logic                        Left,
    output logic                        Right,
    output logic                        valid
);

    localparam int MAX_PHASE = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CNT_W     = $clog2(MAX_PHASE);
    localparam int POLL_W    = $clog2(POLL_CYCLES);

    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [3:0]        IDX_LAST   = 4'(NUM_BITS - 1);

    logic                data_sync;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [3:0]          idx_q,     idx_d;
    logic [POLL_W-1:0]   poll_q,    poll_d;
    logic [NUM_BITS-1:0] shift_q,   shift_d;
    logic [NUM_BITS-1:0] buttons_q, buttons_d;
    logic                latch_q,   latch_d;
    logic                sclk_q,    sclk_d;
    logic                valid_q,   valid_d;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_data_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad.snes_data),
        .q     (data_sync)
    );

    // Pin levels are computed one cycle ahead so latch/clock leave the block straight from flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        latch_d   = latch_q;
        sclk_d    = sclk_q;
        valid_d   = 1'b0;
        poll_d    = (poll_q == POLL_LAST) ? '0 : poll_q + POLL_W'(1);

        case (state_q)
            IDLE: begin
                if (poll_q == POLL_LAST) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                    latch_d = 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = CLK_LO;
                    cnt_d   = '0;
                    idx_d   = '0;
                    latch_d = 1'b0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLK_LO: begin
                if (cnt_q == HALF_LAST) begin
                    shift_d[idx_q] = data_sync;
                    state_d        = CLK_HI;
                    cnt_d          = '0;
                    sclk_d         = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLK_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d   = DONE;
                        buttons_d = shift_q;
                        valid_d   = 1'b1;
                    end else begin
                        state_d = CLK_LO;
                        idx_d   = idx_q + 4'd1;
                        sclk_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                latch_d = 1'b0;
                sclk_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            poll_q    <= '0;
            shift_q   <= '1;
            buttons_q <= '1;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            poll_q    <= poll_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            latch_q   <= latch_d;
            sclk_q    <= sclk_d;
            valid_q   <= valid_d;
        end
    end

    assign pad.snes_latch = latch_q;
    assign pad.snes_clk   = sclk_q;
    assign buttons_n      = buttons_q;
    assign Up             = buttons_q[BTN_UP];
    assign Down           = buttons_q[BTN_DOWN];
    assign Left           = buttons_q[BTN_LEFT];
    assign Right          = buttons_q[BTN_RIGHT];
    assign valid          = valid_q;

endmodule
